// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: turns one (x, y, w, h, colour) command into raster-order pixel writes, clipped to the screen.
// Latency: first write the cycle after acceptance, one write per cycle, done pulse the cycle after the last write.
// Backpressure: cmd_ready only in IDLE; the pixel stream itself is never stalled.
module vga_rect_fill #(
    parameter RESOLUTION = "640x480",
    parameter int COLOR_DEPTH = 9,
    parameter int nX = (RESOLUTION == "320x240") ? 9 : (RESOLUTION == "160x120") ? 8 : 10,
    parameter int nY = (RESOLUTION == "320x240") ? 8 : (RESOLUTION == "160x120") ? 7 : 9
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [nX-1:0]          cmd_x,
    input  logic [nY-1:0]          cmd_y,
    input  logic [nX:0]            cmd_w,
    input  logic [nY:0]            cmd_h,
    input  logic [COLOR_DEPTH-1:0] cmd_color,
    output logic [nX-1:0]          x,
    output logic [nY-1:0]          y,
    output logic [COLOR_DEPTH-1:0] color,
    output logic                   write,
    output logic                   busy,
    output logic                   done
);

    localparam int XMAX = (RESOLUTION == "320x240") ? 320 : (RESOLUTION == "160x120") ? 160 : 640;
    localparam int YMAX = (RESOLUTION == "320x240") ? 240 : (RESOLUTION == "160x120") ? 120 : 480;
    localparam logic [nX:0] XMAX_V = (nX+1)'(XMAX);
    localparam logic [nY:0] YMAX_V = (nY+1)'(YMAX);

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

    state_t state, state_n;

    logic [nX-1:0] x0;
    logic [nX:0]   xe;
    logic [nY:0]   ye;

    // Sums carry an extra bit so origin + size can never wrap before clipping.
    logic [nX+1:0] sum_x;
    logic [nY+1:0] sum_y;
    logic [nX:0]   xe_n;
    logic [nY:0]   ye_n;
    logic          empty;
    logic [nX:0]   x_inc;
    logic [nY:0]   y_inc;
    logic          x_wrap;
    logic          last;

    always_comb begin
        sum_x  = {2'b00, cmd_x} + {1'b0, cmd_w};
        sum_y  = {2'b00, cmd_y} + {1'b0, cmd_h};
        xe_n   = (sum_x > {1'b0, XMAX_V}) ? XMAX_V : sum_x[nX:0];
        ye_n   = (sum_y > {1'b0, YMAX_V}) ? YMAX_V : sum_y[nY:0];
        empty  = (cmd_w == '0) || (cmd_h == '0) ||
                 ({1'b0, cmd_x} >= XMAX_V) || ({1'b0, cmd_y} >= YMAX_V);
        x_inc  = {1'b0, x} + (nX+1)'(1);
        y_inc  = {1'b0, y} + (nY+1)'(1);
        x_wrap = (x_inc >= xe);
        last   = x_wrap && (y_inc >= ye);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        write     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_n = empty ? FIN : DRAW;
                end
            end
            DRAW: begin
                write = 1'b1;
                busy  = 1'b1;
                if (last) begin
                    state_n = FIN;
                end
            end
            FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Empty commands leave x/y/color untouched since no write will follow.
    always_ff @(posedge clock) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            color <= '0;
            x0    <= '0;
            xe    <= '0;
            ye    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && !empty) begin
                        x     <= cmd_x;
                        y     <= cmd_y;
                        color <= cmd_color;
                        x0    <= cmd_x;
                        xe    <= xe_n;
                        ye    <= ye_n;
                    end
                end
                DRAW: begin
                    if (!last) begin
                        if (!x_wrap) begin
                            x <= x_inc[nX-1:0];
                        end else begin
                            x <= x0;
                            y <= y_inc[nY-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
